// File: rtl/one_to_four_demux.sv
// 1-to-4 registered demultiplexer: F is routed to the output selected by {a,b}.
// Every other output is driven to zero. Reset is synchronous and active-high.

module one_to_four_demux_lane #(
  parameter int         DATA_W    = 1,
  parameter int         RESET_VAL = 0,
  parameter logic [1:0] IDX       = 2'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);
  localparam logic [DATA_W-1:0] RST_WORD = (RESET_VAL != 0) ? '1 : '0;

  always_ff @(posedge clk) begin
    if (rst)             q <= RST_WORD;
    else if (sel == IDX) q <= din;
    else                 q <= '0;
  end
endmodule

module one_to_four_demux #(
  parameter int DATA_W    = 1,
  parameter int RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a,
  input  logic              b,
  input  logic [DATA_W-1:0] F,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] C,
  output logic [DATA_W-1:0] D
);
  localparam int NUM_LANES = 4;

  logic [1:0]                        sel;
  logic [NUM_LANES-1:0][DATA_W-1:0]  outs;

  assign sel = {a, b};

  // One registered lane per output; lane i claims F when sel equals i.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    one_to_four_demux_lane #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL),
      .IDX       (2'(i))
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .sel (sel),
      .din (F),
      .q   (outs[i])
    );
  end

  assign A = outs[0];
  assign B = outs[1];
  assign C = outs[2];
  assign D = outs[3];
endmodule

// File: tb/tb_one_to_four_demux.sv
// Scoreboard bench: a 1-bit and an 8-bit demux share select/reset; expected
// outputs are queued per edge and checked after the edge and again mid-cycle.

module tb_one_to_four_demux;
  logic       clk = 1'b0;
  logic       rst, a, b;
  logic       f1;
  logic [7:0] f8;
  logic       a1, b1, c1, d1;
  logic [7:0] a8, b8, c8, d8;

  typedef struct {
    logic [3:0]      o1;
    logic [3:0][7:0] o8;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  always #5 clk = ~clk;

  one_to_four_demux #(.DATA_W(1), .RESET_VAL(0)) dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .F(f1),
    .A(a1), .B(b1), .C(c1), .D(d1)
  );

  one_to_four_demux #(.DATA_W(8), .RESET_VAL(0)) dut8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .F(f8),
    .A(a8), .B(b8), .C(c8), .D(d8)
  );

  // Reference: reset clears everything, otherwise slot {a,b} holds F.
  function automatic exp_t model(input logic r, input logic sa, input logic sb,
                                 input logic v1, input logic [7:0] v8);
    exp_t e;
    int   s;
    e.o1 = '0;
    e.o8 = '0;
    s = sa * 2 + sb;
    if (!r) begin
      e.o1[s] = v1;
      e.o8[s] = v8;
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic sa, input logic sb,
                      input logic v1, input logic [7:0] v8);
    @(negedge clk);
    rst = r; a = sa; b = sb; f1 = v1; f8 = v8;
    exp_q.push_back(model(r, sa, sb, v1, v8));
  endtask

  task automatic compare(input string tag, input exp_t e);
    logic [3:0]      got1;
    logic [3:0][7:0] got8;
    got1 = {d1, c1, b1, a1};
    got8 = {d8, c8, b8, a8};
    checks++;
    if (got1 !== e.o1) begin
      errors++;
      $display("FAIL %s w1 t=%0t got DCBA=%b want %b", tag, $time, got1, e.o1);
    end
    checks++;
    if (got8 !== e.o8) begin
      errors++;
      $display("FAIL %s w8 t=%0t got DCBA=%h want %h", tag, $time, got8, e.o8);
    end
  endtask

  // Monitor: after each edge pop and compare; after the mid-cycle input change
  // the outputs must still hold the same value.
  initial begin
    exp_t cur;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        compare("edge", cur);
        @(negedge clk);
        #1;
        compare("hold", cur);
      end
    end
  end

  initial begin
    rst = 1'b1; a = 1'b1; b = 1'b1; f1 = 1'b1; f8 = 8'hFF;

    // reset held two cycles with sel=11, F=1, then release
    step(1, 1, 1, 1, 8'hFF);
    step(1, 1, 1, 1, 8'hFF);
    step(0, 1, 1, 1, 8'hFF);

    // exhaustive {a,b,F}
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step(0, v[2], v[1], v[0], v[0] ? 8'h5A : 8'h00);
    end

    // toggle pattern: a every 5, b every 10, F every 20
    for (int i = 0; i < 100; i++) begin
      logic ta, tb, tf;
      ta = 1'((i / 5) % 2);
      tb = 1'((i / 10) % 2);
      tf = 1'((i / 20) % 2);
      step(0, ta, tb, tf, tf ? 8'hC3 : 8'h00);
    end

    // latency: sel 00 -> 11 with F=1 (mid-cycle hold checked by monitor)
    step(0, 0, 0, 1, 8'h81);
    step(0, 1, 1, 1, 8'h81);
    step(0, 1, 1, 1, 8'h81);

    // reset mid-stream with B selected
    step(0, 0, 1, 1, 8'h3C);
    step(0, 0, 1, 1, 8'h3C);
    step(1, 0, 1, 1, 8'h3C);
    step(0, 0, 1, 1, 8'h3C);
    step(0, 0, 1, 1, 8'h3C);

    // width: sel=10 with A5, then sel=01
    step(0, 1, 0, 1, 8'hA5);
    step(0, 0, 1, 1, 8'hA5);
    step(0, 0, 1, 0, 8'h00);

    // random traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
           1'($urandom), 8'($urandom));
    end

    // drain: wait for the monitor to consume everything, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    done = 1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
